// File: rtl/mac512_pkg.sv
// Shared definitions for the MAC_512 accumulation path.
//
// Contents:
//   CLA_SLICE : width of the single carry-lookahead slice (32 bits).
//   state_e   : sequencer states (IDLE, RUN, DONE).
//   clog2     : ceiling log2 helper, never returns less than 1 so a
//               counter built from it always has at least one bit.
package mac512_pkg;

  localparam int CLA_SLICE = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/wide_add_seq_cla32.sv
// CLA32: 32-bit two-level carry-lookahead adder slice.
//
// Ports:
//   a, b  : 32-bit addends.
//   ci    : carry into bit 0.
//   s     : 32-bit sum.
//   g, p  : group generate / propagate for the whole 32-bit slice, so a
//           caller can form the slice carry-out as g | (p & carry_in).
//   co    : carry out of bit 31.
//
// Bits are grouped into eight 4-bit lookahead blocks; the block carries are
// resolved from block generate/propagate, then expanded inside each block.
module cla32
  import mac512_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        g,
  output logic        p,
  output logic        co
);

  always_comb begin
    logic [31:0] bit_g;
    logic [31:0] bit_p;
    logic [32:0] c;
    logic [7:0]  blk_g;
    logic [7:0]  blk_p;
    logic [8:0]  blk_c;
    logic        grp_g;
    logic        grp_p;

    bit_g = a & b;
    bit_p = a ^ b;
    c     = '0;
    blk_g = '0;
    blk_p = '0;
    blk_c = '0;
    grp_g = 1'b0;
    grp_p = 1'b1;

    // Per-block generate/propagate, written out in lookahead form.
    for (int i = 0; i < 8; i++) begin
      blk_g[i] = bit_g[4*i+3]
               | (bit_p[4*i+3] & bit_g[4*i+2])
               | (bit_p[4*i+3] & bit_p[4*i+2] & bit_g[4*i+1])
               | (bit_p[4*i+3] & bit_p[4*i+2] & bit_p[4*i+1] & bit_g[4*i]);
      blk_p[i] = &bit_p[4*i +: 4];
    end

    // Block-level carries, then bit-level carries within each block.
    blk_c[0] = ci;
    for (int i = 0; i < 8; i++) begin
      blk_c[i+1] = blk_g[i] | (blk_p[i] & blk_c[i]);
    end

    for (int i = 0; i < 8; i++) begin
      c[4*i] = blk_c[i];
      for (int j = 0; j < 3; j++) begin
        c[4*i+j+1] = bit_g[4*i+j] | (bit_p[4*i+j] & c[4*i+j]);
      end
    end
    c[32] = blk_c[8];

    // Whole-slice generate/propagate folded from the block terms.
    for (int i = 0; i < 8; i++) begin
      grp_g = blk_g[i] | (blk_p[i] & grp_g);
      grp_p = grp_p & blk_p[i];
    end

    s  = bit_p ^ c[31:0];
    g  = grp_g;
    p  = grp_p;
    co = c[32];
  end

endmodule

// File: rtl/wide_add_seq.sv
// wide_add_seq: multi-cycle WIDTH-bit adder built from one CLA32 slice.
//
// The operands are shifted through the slice LSB first, one 32-bit slice
// per clock, with the inter-slice carry held in a register. The result
// builds up in a sum shift register that fills from the top.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset.
//   in_valid/ready  : operand handshake (ready only in IDLE).
//   a, b, ci        : operands and carry-in, sampled at the accept edge.
//   out_valid/ready : result handshake (valid only in DONE).
//   sum, cout       : registered (a + b + ci) mod 2^WIDTH and carry-out.
//   busy            : high while an operation is in RUN or DONE.
module wide_add_seq
  import mac512_pkg::*;
#(
  parameter int WIDTH = 512,
  parameter int SLICE = CLA_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = clog2(NSLICE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic [SLICE-1:0]   slice_sum;
  logic               slice_g;
  logic               slice_p;
  logic               slice_co;
  logic               cla_co_unused;

  cla32 u_cla32 (
    .a  (a_sr_q[SLICE-1:0]),
    .b  (b_sr_q[SLICE-1:0]),
    .ci (carry_q),
    .s  (slice_sum),
    .g  (slice_g),
    .p  (slice_p),
    .co (cla_co_unused)
  );

  // Carry into the next slice comes from the group terms and the carry
  // register rather than the slice's own ripple output.
  assign slice_co = slice_g | (slice_p & carry_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = ci;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sr_d  = a_sr_q >> SLICE;
        b_sr_d  = b_sr_q >> SLICE;
        sum_d   = {slice_sum, sum_q[WIDTH-1:SLICE]};
        carry_d = slice_co;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_co;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq at the default 512-bit width.
module tb_wide_add_seq;

  localparam int W  = 512;
  localparam int NS = W / 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int checks;
  int errors;
  int pushes;
  int hs_count;

  logic [W:0] exp_q[$];

  wide_add_seq #(.WIDTH(W), .SLICE(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts every completed result handshake seen by the consumer.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      hs_count = hs_count + 1;
    end
  end

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for in_ready, offers one operand set for one accepting edge and
  // optionally records the reference result in the scoreboard.
  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                               input logic tci, input bit push);
    int n;
    logic [W:0] full;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
    end
    a        = ta;
    b        = tb_v;
    ci       = tci;
    in_valid = 1'b1;
    if (push) begin
      full = {1'b0, ta} + {1'b0, tb_v} + {{W{1'b0}}, tci};
      exp_q.push_back(full);
      pushes++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    ci       = 1'b0;
  endtask

  // Waits for out_valid, optionally checks latency, stalls, then compares
  // the result against the scoreboard and completes the handshake.
  task automatic checkOutput(input string tag, input int stall, input bit chk_lat);
    int n;
    logic [W:0] exp;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (chk_lat) begin
      check({tag, "_latency"}, (W+1)'(n), (W+1)'(NS));
    end
    if (!out_valid) begin
      check({tag, "_out_valid_timeout"}, {{W{1'b0}}, out_valid}, {{W{1'b0}}, 1'b1});
      return;
    end
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
    end
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, (W+1)'(0), (W+1)'(1));
      exp = '0;
    end else begin
      exp = exp_q.pop_front();
    end
    check(tag, {cout, sum}, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W:0]   held;
    logic [W-1:0] ones;
    logic [W-1:0] top;

    checks    = 0;
    errors    = 0;
    pushes    = 0;
    hs_count  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    ci        = 1'b0;
    ones      = '1;
    top       = '0;
    top[W-1]  = 1'b1;

    repeat (3) @(negedge clk);
    check("reset_in_ready",  (W+1)'(in_ready),  (W+1)'(1));
    check("reset_out_valid", (W+1)'(out_valid), (W+1)'(0));
    check("reset_busy",      (W+1)'(busy),      (W+1)'(0));
    check("reset_sum_cout",  {cout, sum},       (W+1)'(0));
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed additions");
    applyStimulus((W)'(1), (W)'(1), 1'b0, 1'b1);
    checkOutput("one_plus_one", 0, 1'b1);
    check("idle_after_done", (W+1)'({in_ready, out_valid, busy}), (W+1)'(3'b100));

    applyStimulus(ones, '0, 1'b1, 1'b1);
    checkOutput("all_ones_ci", 0, 1'b1);

    applyStimulus(top, top, 1'b0, 1'b1);
    checkOutput("msb_overflow", 1, 1'b1);

    applyStimulus((W)'(32'hFFFF_FFFF), (W)'(1), 1'b0, 1'b1);
    checkOutput("slice_carry", 0, 1'b1);

    $display("[TB] stall in DONE with ignored inputs");
    applyStimulus((W)'(64'h1234_5678_9ABC_DEF0), (W)'(64'h0FED_CBA9_8765_4321), 1'b1, 1'b1);
    while (!out_valid) @(negedge clk);
    held = {cout, sum};
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      a        = (W)'(k + 100);
      b        = (W)'(k + 200);
      ci       = 1'b1;
      @(negedge clk);
      check("stall_out_valid", (W+1)'(out_valid), (W+1)'(1));
      check("stall_in_ready",  (W+1)'(in_ready),  (W+1)'(0));
      check("stall_held",      {cout, sum},       held);
    end
    in_valid = 1'b0;
    checkOutput("stall_result", 0, 1'b0);
    check("stall_release_idle", (W+1)'({in_ready, busy}), (W+1)'(2'b10));

    $display("[TB] reset in the middle of RUN");
    applyStimulus((W)'(3), (W)'(4), 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_flags", (W+1)'({in_ready, out_valid, busy}), (W+1)'(3'b100));
    check("midrun_reset_sum",   {cout, sum},                         (W+1)'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus((W)'(5), (W)'(7), 1'b0, 1'b1);
    checkOutput("after_reset", 0, 1'b1);

    $display("[TB] random back-to-back operations");
    for (int n = 0; n < 100; n++) begin
      for (int k = 0; k < NS; k++) begin
        ra[k*32 +: 32] = $urandom;
        rb[k*32 +: 32] = $urandom;
      end
      if (n % 10 == 3) rb = ~ra;
      applyStimulus(ra, rb, 1'($urandom_range(0, 1)), 1'b1);
      checkOutput("random", int'($urandom_range(0, 3)), 1'b0);
    end

    @(negedge clk);
    check("handshake_count", (W+1)'(hs_count),     (W+1)'(pushes));
    check("scoreboard_left", (W+1)'(exp_q.size()), (W+1)'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
